// File: rtl/hvac_pkg.sv
// hvac_pkg: shared types and constants for the HVAC sequencer.
//   hvac_state_e : FSM state encoding (IDLE=0, HEAT=1, COOL=2, LOCKOUT=3)
//   TEMP_W       : temperature input width
//   CMP_W        : width used for all temperature compares (one guard bit, no wrap)
package hvac_pkg;

    localparam int unsigned TEMP_W = 8;
    localparam int unsigned CMP_W  = TEMP_W + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeat    = 2'd1,
        StCool    = 2'd2,
        StLockout = 2'd3
    } hvac_state_e;

endpackage

// File: rtl/hvac_dwell_timer.sv
// hvac_dwell_timer: dwell counter for the HVAC sequencer.
// Clears to 0, otherwise increments each cycle and saturates at the terminal value.
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   clr     : load 0 on the next edge (used on state entry)
//   term    : terminal value selected by the FSM
//   at_term : high while the count equals term
module hvac_dwell_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_term = (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!at_term) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heater/cooler sequencer with hysteresis, minimum run time and
// compressor lockout. Heating and cooling never switch directly; every run ends in LOCKOUT.
// Optional feature macro: HVAC_ECO_SETBACK_EN (energySavingMode widens the band by ECO_BAND).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : master enable
//   currentTemp       : measured temperature (unsigned)
//   desiredTemp       : setpoint (unsigned)
//   windowOpen        : forces a stop and inhibits starting
//   energySavingMode  : widens the band (only with HVAC_ECO_SETBACK_EN)
//   heaterOn/coolerOn : run outputs, decoded from state
//   lockoutActive     : high in LOCKOUT
//   hvacState         : current state encoding
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int unsigned HYST        = 2,
    parameter int unsigned MIN_RUN_CYC = 16,
    parameter int unsigned LOCKOUT_CYC = 8,
    parameter int unsigned ECO_BAND    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [TEMP_W-1:0] currentTemp,
    input  logic [TEMP_W-1:0] desiredTemp,
    input  logic              windowOpen,
    input  logic              energySavingMode,
    output logic              heaterOn,
    output logic              coolerOn,
    output logic              lockoutActive,
    output logic [1:0]        hvacState
);

    localparam int unsigned CNT_MAX = (MIN_RUN_CYC > LOCKOUT_CYC) ? MIN_RUN_CYC : LOCKOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_TERM  = CNT_W'(MIN_RUN_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCKOUT_CYC - 1);

    hvac_state_e state_q, state_d;

    logic [CMP_W-1:0] cur_w, des_w, band_w;
    logic             heat_req, cool_req, heat_done, cool_done, inhibit;
    logic             cnt_clr, at_term;
    logic [CNT_W-1:0] cnt_term;

    // Zero-extend so cur+band and des+band cannot wrap.
    assign cur_w = {{(CMP_W - TEMP_W){1'b0}}, currentTemp};
    assign des_w = {{(CMP_W - TEMP_W){1'b0}}, desiredTemp};

`ifdef HVAC_ECO_SETBACK_EN
    always_comb begin
        band_w = CMP_W'(HYST);
        if (energySavingMode) begin
            band_w = CMP_W'(HYST) + CMP_W'(ECO_BAND);
        end
    end
`else
    logic unused_eco;
    assign unused_eco = energySavingMode | ECO_BAND[0];
    assign band_w     = CMP_W'(HYST);
`endif

    assign heat_req  = (cur_w + band_w) < des_w;
    assign cool_req  = cur_w > (des_w + band_w);
    assign heat_done = cur_w >= des_w;
    assign cool_done = cur_w <= des_w;
    assign inhibit   = !enable || windowOpen;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!inhibit) begin
                    if (heat_req) begin
                        state_d = StHeat;
                    end else if (cool_req) begin
                        state_d = StCool;
                    end
                end
            end
            StHeat: begin
                if (inhibit || (heat_done && at_term)) begin
                    state_d = StLockout;
                end
            end
            StCool: begin
                if (inhibit || (cool_done && at_term)) begin
                    state_d = StLockout;
                end
            end
            StLockout: begin
                if (at_term) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter restarts from 0 on every state entry; held clear while idle.
    always_comb begin
        cnt_term = RUN_TERM;
        if (state_q == StLockout) begin
            cnt_term = LOCK_TERM;
        end
        cnt_clr = (state_d != state_q) || (state_q == StIdle);
    end

    hvac_dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .term   (cnt_term),
        .at_term(at_term)
    );

    // Outputs decoded from the state register only
    always_comb begin
        heaterOn      = 1'b0;
        coolerOn      = 1'b0;
        lockoutActive = 1'b0;
        hvacState     = state_q;
        unique case (state_q)
            StHeat:    heaterOn      = 1'b1;
            StCool:    coolerOn      = 1'b1;
            StLockout: lockoutActive = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_hvac_sequencer.sv
// tb_hvac_sequencer: directed scoreboard bench for hvac_sequencer (default parameters).
module tb_hvac_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAT = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

`ifdef HVAC_ECO_SETBACK_EN
    localparam logic [1:0] ECO_EXP = S_IDLE;
`else
    localparam logic [1:0] ECO_EXP = S_HEAT;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] currentTemp;
    logic [7:0] desiredTemp;
    logic       windowOpen;
    logic       energySavingMode;
    logic       heaterOn;
    logic       coolerOn;
    logic       lockoutActive;
    logic [1:0] hvacState;

    hvac_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .currentTemp     (currentTemp),
        .desiredTemp     (desiredTemp),
        .windowOpen      (windowOpen),
        .energySavingMode(energySavingMode),
        .heaterOn        (heaterOn),
        .coolerOn        (coolerOn),
        .lockoutActive   (lockoutActive),
        .hvacState       (hvacState)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    event sample_ev;

    // Expected {hvacState, heaterOn, coolerOn, lockoutActive} for a state
    function automatic logic [4:0] expand(input logic [1:0] st);
        return {st, st == S_HEAT, st == S_COOL, st == S_LOCK};
    endfunction

    // Monitor: one expected entry per output sample
    always begin
        exp_t       e;
        logic [4:0] got;
        logic [4:0] want;
        @(negedge clk or sample_ev);
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            got  = {hvacState, heaterOn, coolerOn, lockoutActive};
            want = expand(e.st);
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got state/heat/cool/lock=%b want %b (t=%0t)",
                         e.name, got, want, $time);
            end
        end
    end

    // Push expectation for the state after the next clock edge
    task automatic cycle(input logic [1:0] st, input string name);
        exp_t e;
        e.st   = st;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n, input logic [1:0] st, input string name);
        for (int i = 0; i < n; i++) cycle(st, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1; enable = 1'b0; currentTemp = 8'd0; desiredTemp = 8'd0;
        windowOpen = 1'b0; energySavingMode = 1'b0;
        cycles(2, S_IDLE, "reset_state");
        reset = 1'b0;

        // Normal heat run: done from cycle 3, still 16 cycles of HEAT, 8 of LOCKOUT
        enable = 1'b1; currentTemp = 8'd18; desiredTemp = 8'd22;
        cycles(3, S_HEAT, "heat_start");
        currentTemp = 8'd22;
        cycles(13, S_HEAT, "heat_min_run");
        cycles(8, S_LOCK, "heat_lockout");
        cycles(2, S_IDLE, "heat_back_idle");

        // Forced stop by window at cnt=4, window held keeps IDLE after lockout
        currentTemp = 8'd18;
        cycles(5, S_HEAT, "force_heat");
        windowOpen = 1'b1;
        cycles(8, S_LOCK, "window_lockout");
        cycles(3, S_IDLE, "window_inhibit");
        windowOpen = 1'b0;
        cycle(S_HEAT, "window_cleared");
        enable = 1'b0;
        cycles(8, S_LOCK, "disable_lockout");
        cycle(S_IDLE, "disable_idle");

        // Overflow corners
        enable = 1'b1; currentTemp = 8'd255; desiredTemp = 8'd254;
        cycles(2, S_IDLE, "ovf_no_cool");
        currentTemp = 8'd0; desiredTemp = 8'd255;
        cycle(S_HEAT, "ovf_heat");
        enable = 1'b0;
        cycles(8, S_LOCK, "ovf_heat_lockout");
        cycle(S_IDLE, "ovf_idle");
        enable = 1'b1; currentTemp = 8'd255; desiredTemp = 8'd0;
        cycles(3, S_COOL, "ovf_cool");

        // Asynchronous reset mid-COOL, restart without lockout
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        e.st = S_IDLE; e.name = "reset_async";
        exp_q.push_back(e);
        -> sample_ev;
        #1;
        reset = 1'b0; currentTemp = 8'd30; desiredTemp = 8'd22;
        cycles(2, S_COOL, "cool_after_reset");
        enable = 1'b0;
        cycles(8, S_LOCK, "cool_lockout");
        cycle(S_IDLE, "cool_idle");

        // Hysteresis boundary and eco band
        enable = 1'b1; currentTemp = 8'd20; desiredTemp = 8'd22;
        cycles(2, S_IDLE, "hyst_heat_edge");
        currentTemp = 8'd19; energySavingMode = 1'b1;
        cycle(ECO_EXP, "eco_band");
        energySavingMode = 1'b0;
        cycle(S_HEAT, "hyst_heat");
        windowOpen = 1'b1;
        cycles(8, S_LOCK, "hyst_lockout");
        cycle(S_IDLE, "hyst_idle");
        windowOpen = 1'b0;

        // Cool boundary, saturation past min run, then normal cool stop
        currentTemp = 8'd24;
        cycle(S_IDLE, "hyst_cool_edge");
        currentTemp = 8'd25;
        cycles(20, S_COOL, "cool_saturate");
        currentTemp = 8'd22;
        cycles(8, S_LOCK, "cool_done_lockout");
        cycles(2, S_IDLE, "cool_done_idle");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
